trap_ctrl: RTL and testbench

Trap sequencer between the write-back stage and the CSR file. It detects synchronous exceptions and enabled machine interrupts at the WB retire point, and picks the winning cause. It then runs a fixed multi-cycle sequence: flush the pipeline, commit mepc/mcause/mtval, redirect fetch. It sequences MRET the same way, redirecting to mepc.

---
 rtl/trap_pkg.sv | 36 +++
 rtl/trap_prio_enc.sv | 78 +++++++
 rtl/trap_ctrl.sv | 174 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, cause codes,
// tval source selection and mtvec mode encodings.
package trap_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FLUSH    = 3'd1,
        S_COMMIT   = 3'd2,
        S_RET      = 3'd3,
        S_REDIRECT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        TVAL_ZERO = 2'd0,
        TVAL_PC   = 2'd1,
        TVAL_INST = 2'd2,
        TVAL_ADDR = 2'd3
    } tval_sel_e;

    // Exception codes (mcause[XLEN-1]=0)
    localparam logic [3:0] CAUSE_INST_MIS = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] CAUSE_BREAK    = 4'd3;
    localparam logic [3:0] CAUSE_LD_MIS   = 4'd4;
    localparam logic [3:0] CAUSE_ST_MIS   = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M  = 4'd11;

    // Interrupt codes (mcause[XLEN-1]=1)
    localparam logic [3:0] CAUSE_INT_MSI  = 4'd3;
    localparam logic [3:0] CAUSE_INT_MTI  = 4'd7;
    localparam logic [3:0] CAUSE_INT_MEI  = 4'd11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational winner selection among enabled interrupts, synchronous
// exceptions and MRET for the instruction at the WB retire point.
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic       i_valid,
    input  logic       i_mstatus_mie,
    input  logic       i_meip,
    input  logic       i_msip,
    input  logic       i_mtip,
    input  logic       i_mie_mei,
    input  logic       i_mie_msi,
    input  logic       i_mie_mti,
    input  logic       i_inst_mis,
    input  logic       i_illegal,
    input  logic       i_break,
    input  logic       i_ecall,
    input  logic       i_ld_mis,
    input  logic       i_st_mis,
    input  logic       i_mret,
    output logic       o_take,
    output logic       o_is_int,
    output logic       o_is_mret,
    output logic [3:0] o_code,
    output tval_sel_e  o_tval_sel
);

    logic w_mei;
    logic w_msi;
    logic w_mti;

    assign w_mei = i_mstatus_mie & i_meip & i_mie_mei;
    assign w_msi = i_mstatus_mie & i_msip & i_mie_msi;
    assign w_mti = i_mstatus_mie & i_mtip & i_mie_mti;

    always_comb begin
        o_take     = 1'b0;
        o_is_int   = 1'b0;
        o_is_mret  = 1'b0;
        o_code     = CAUSE_INST_MIS;
        o_tval_sel = TVAL_ZERO;
        if (i_valid) begin
            o_take = 1'b1;
            if (w_mei) begin
                o_is_int = 1'b1;
                o_code   = CAUSE_INT_MEI;
            end else if (w_msi) begin
                o_is_int = 1'b1;
                o_code   = CAUSE_INT_MSI;
            end else if (w_mti) begin
                o_is_int = 1'b1;
                o_code   = CAUSE_INT_MTI;
            end else if (i_inst_mis) begin
                o_code     = CAUSE_INST_MIS;
                o_tval_sel = TVAL_PC;
            end else if (i_illegal) begin
                o_code     = CAUSE_ILLEGAL;
                o_tval_sel = TVAL_INST;
            end else if (i_break) begin
                o_code     = CAUSE_BREAK;
                o_tval_sel = TVAL_PC;
            end else if (i_ecall) begin
                o_code = CAUSE_ECALL_M;
            end else if (i_ld_mis) begin
                o_code     = CAUSE_LD_MIS;
                o_tval_sel = TVAL_ADDR;
            end else if (i_st_mis) begin
                o_code     = CAUSE_ST_MIS;
                o_tval_sel = TVAL_ADDR;
            end else if (i_mret) begin
                o_is_mret = 1'b1;
            end else begin
                o_take = 1'b0;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer between WB and the CSR file: capture at retire, then
// FLUSH -> COMMIT|RET -> REDIRECT, with the pipeline stalled throughout.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wb_valid_i,
    input  logic [XLEN-1:0] wb_pc_i,
    input  logic [31:0]     wb_inst_i,
    input  logic [XLEN-1:0] wb_mem_addr_i,
    input  logic            e_inst_addr_mis_i,
    input  logic            e_illegal_inst_i,
    input  logic            e_break_i,
    input  logic            e_ecall_i,
    input  logic            e_ld_addr_mis_i,
    input  logic            e_st_addr_mis_i,
    input  logic            is_mret_i,
    input  logic            xint_meip_i,
    input  logic            xint_msip_i,
    input  logic            xint_mtip_i,
    input  logic            mstatus_mie_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            stall_o,
    output logic            flush_o,
    output logic            trap_we_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mret_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    state_e          r_state;
    state_e          w_next;
    logic            r_is_mret;
    logic            r_is_int;
    logic [3:0]      r_code;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_ret_pc;

    logic            w_take;
    logic            w_is_int;
    logic            w_is_mret;
    logic [3:0]      w_code;
    tval_sel_e       w_tval_sel;
    logic [XLEN-1:0] w_tval;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_trap_pc;
    logic            w_vectored;
    logic            w_capture;
    logic            w_unused_mie;

    assign w_unused_mie = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

    trap_prio_enc u_prio (
        .i_valid       (wb_valid_i),
        .i_mstatus_mie (mstatus_mie_i),
        .i_meip        (xint_meip_i),
        .i_msip        (xint_msip_i),
        .i_mtip        (xint_mtip_i),
        .i_mie_mei     (mie_i[11]),
        .i_mie_msi     (mie_i[3]),
        .i_mie_mti     (mie_i[7]),
        .i_inst_mis    (e_inst_addr_mis_i),
        .i_illegal     (e_illegal_inst_i),
        .i_break       (e_break_i),
        .i_ecall       (e_ecall_i),
        .i_ld_mis      (e_ld_addr_mis_i),
        .i_st_mis      (e_st_addr_mis_i),
        .i_mret        (is_mret_i),
        .o_take        (w_take),
        .o_is_int      (w_is_int),
        .o_is_mret     (w_is_mret),
        .o_code        (w_code),
        .o_tval_sel    (w_tval_sel)
    );

    always_comb begin
        w_tval = '0;
        case (w_tval_sel)
            TVAL_PC:   w_tval = wb_pc_i;
            TVAL_INST: w_tval = XLEN'(wb_inst_i);
            TVAL_ADDR: w_tval = wb_mem_addr_i;
            default:   w_tval = '0;
        endcase
    end

    assign w_capture  = (r_state == S_IDLE) && w_take;
    assign w_base     = {mtvec_i[XLEN-1:2], 2'b00};
    assign w_vectored = VECTORED_EN && (mtvec_i[1:0] == MTVEC_VECTORED) && r_is_int;
    assign w_trap_pc  = w_vectored ? (w_base + {{(XLEN-6){1'b0}}, r_code, 2'b00}) : w_base;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_is_mret <= 1'b0;
            r_is_int  <= 1'b0;
            r_code    <= '0;
            r_mcause  <= '0;
            r_mtval   <= '0;
            r_mepc    <= '0;
            r_ret_pc  <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_is_mret <= w_is_mret;
                // MRET leaves the trap commit values from the previous trap intact
                if (!w_is_mret) begin
                    r_is_int <= w_is_int;
                    r_code   <= w_code;
                    r_mcause <= {w_is_int, {(XLEN-5){1'b0}}, w_code};
                    r_mtval  <= w_tval;
                    r_mepc   <= wb_pc_i;
                end
            end
            if (r_state == S_RET) begin
                r_ret_pc <= mepc_i;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        stall_o       = 1'b1;
        flush_o       = 1'b0;
        trap_we_o     = 1'b0;
        mret_o        = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        case (r_state)
            S_IDLE: begin
                stall_o = 1'b0;
                if (w_take) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush_o = 1'b1;
                w_next  = r_is_mret ? S_RET : S_COMMIT;
            end
            S_COMMIT: begin
                trap_we_o = 1'b1;
                w_next    = S_REDIRECT;
            end
            S_RET: begin
                mret_o = 1'b1;
                w_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_o    = 1'b1;
                redirect_pc_o = r_is_mret ? {r_ret_pc[XLEN-1:2], 2'b00} : w_trap_pc;
                w_next        = S_IDLE;
            end
            default: begin
                stall_o = 1'b0;
                w_next  = S_IDLE;
            end
        endcase
    end

    assign mcause_o = r_mcause;
    assign mtval_o  = r_mtval;
    assign mepc_o   = r_mepc;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: each driven event queues its expected strobe
// cycles; a negedge monitor pops and compares them as the DUT produces them.
module tb_trap_ctrl;

    localparam int unsigned XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            wb_valid_i = 1'b0;
    logic [XLEN-1:0] wb_pc_i = '0;
    logic [31:0]     wb_inst_i = '0;
    logic [XLEN-1:0] wb_mem_addr_i = '0;
    logic            e_inst_addr_mis_i = 1'b0;
    logic            e_illegal_inst_i = 1'b0;
    logic            e_break_i = 1'b0;
    logic            e_ecall_i = 1'b0;
    logic            e_ld_addr_mis_i = 1'b0;
    logic            e_st_addr_mis_i = 1'b0;
    logic            is_mret_i = 1'b0;
    logic            xint_meip_i = 1'b0;
    logic            xint_msip_i = 1'b0;
    logic            xint_mtip_i = 1'b0;
    logic            mstatus_mie_i = 1'b0;
    logic [XLEN-1:0] mie_i = '0;
    logic [XLEN-1:0] mtvec_i = '0;
    logic [XLEN-1:0] mepc_i = '0;
    logic            stall_o;
    logic            flush_o;
    logic            trap_we_o;
    logic [XLEN-1:0] mcause_o;
    logic [XLEN-1:0] mtval_o;
    logic [XLEN-1:0] mepc_o;
    logic            mret_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;

    trap_ctrl #(
        .XLEN        (XLEN),
        .VECTORED_EN (1'b1)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .wb_valid_i        (wb_valid_i),
        .wb_pc_i           (wb_pc_i),
        .wb_inst_i         (wb_inst_i),
        .wb_mem_addr_i     (wb_mem_addr_i),
        .e_inst_addr_mis_i (e_inst_addr_mis_i),
        .e_illegal_inst_i  (e_illegal_inst_i),
        .e_break_i         (e_break_i),
        .e_ecall_i         (e_ecall_i),
        .e_ld_addr_mis_i   (e_ld_addr_mis_i),
        .e_st_addr_mis_i   (e_st_addr_mis_i),
        .is_mret_i         (is_mret_i),
        .xint_meip_i       (xint_meip_i),
        .xint_msip_i       (xint_msip_i),
        .xint_mtip_i       (xint_mtip_i),
        .mstatus_mie_i     (mstatus_mie_i),
        .mie_i             (mie_i),
        .mtvec_i           (mtvec_i),
        .mepc_i            (mepc_i),
        .stall_o           (stall_o),
        .flush_o           (flush_o),
        .trap_we_o         (trap_we_o),
        .mcause_o          (mcause_o),
        .mtval_o           (mtval_o),
        .mepc_o            (mepc_o),
        .mret_o            (mret_o),
        .redirect_o        (redirect_o),
        .redirect_pc_o     (redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    // strobes = {redirect, mret, trap_we, flush}
    typedef struct {
        logic [3:0]      strobes;
        logic [XLEN-1:0] mcause;
        logic [XLEN-1:0] mtval;
        logic [XLEN-1:0] mepc;
        logic [XLEN-1:0] rpc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_trap(input logic [XLEN-1:0] mc, input logic [XLEN-1:0] tv,
                             input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rpc);
        sb_q.push_back('{4'b0001, '0, '0, '0, '0});
        sb_q.push_back('{4'b0010, mc, tv, pc, '0});
        sb_q.push_back('{4'b1000, '0, '0, '0, rpc});
    endtask

    task automatic push_mret(input logic [XLEN-1:0] rpc);
        sb_q.push_back('{4'b0001, '0, '0, '0, '0});
        sb_q.push_back('{4'b0100, '0, '0, '0, '0});
        sb_q.push_back('{4'b1000, '0, '0, '0, rpc});
    endtask

    task automatic clear_events();
        wb_valid_i        = 1'b0;
        e_inst_addr_mis_i = 1'b0;
        e_illegal_inst_i  = 1'b0;
        e_break_i         = 1'b0;
        e_ecall_i         = 1'b0;
        e_ld_addr_mis_i   = 1'b0;
        e_st_addr_mis_i   = 1'b0;
        is_mret_i         = 1'b0;
        xint_meip_i       = 1'b0;
        xint_msip_i       = 1'b0;
        xint_mtip_i       = 1'b0;
    endtask

    // Present the prepared WB inputs for one edge, then let the 3-cycle sequence run;
    // returns in the first IDLE cycle so a following call is back-to-back.
    task automatic fire();
        wb_valid_i = 1'b1;
        @(posedge clk_i); #1;
        clear_events();
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        logic [3:0] st;
        exp_t       e;
        if (rst_i) begin
            st = {redirect_o, mret_o, trap_we_o, flush_o};
            if (!stall_o) begin
                check("idle_strobes", {60'd0, st}, 64'd0);
            end else begin
                check("onehot", 64'($countones(st)), 64'd1);
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", {60'd0, st}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("strobes", {60'd0, st}, {60'd0, e.strobes});
                    if (e.strobes[1]) begin
                        check("mcause", 64'(mcause_o), 64'(e.mcause));
                        check("mtval",  64'(mtval_o),  64'(e.mtval));
                        check("mepc",   64'(mepc_o),   64'(e.mepc));
                    end
                    if (e.strobes[3]) begin
                        check("redirect_pc", 64'(redirect_pc_o), 64'(e.rpc));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_stall",  64'(stall_o), 64'd0);
        check("rst_mcause", 64'(mcause_o), 64'd0);
        check("rst_rpc",    64'(redirect_pc_o), 64'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Illegal instruction, direct mtvec
        mtvec_i = 32'h200;
        wb_pc_i = 32'h100; wb_inst_i = 32'hFFFF_FFFF; e_illegal_inst_i = 1'b1;
        push_trap(32'd2, 32'hFFFF_FFFF, 32'h100, 32'h200);
        fire();

        // ld_mis + illegal: illegal wins; then ld_mis alone
        wb_pc_i = 32'h40; wb_inst_i = 32'h1234_5678; wb_mem_addr_i = 32'h1003;
        e_illegal_inst_i = 1'b1; e_ld_addr_mis_i = 1'b1;
        push_trap(32'd2, 32'h1234_5678, 32'h40, 32'h200);
        fire();
        e_ld_addr_mis_i = 1'b1;
        push_trap(32'd4, 32'h1003, 32'h40, 32'h200);
        fire();

        // inst_mis beats everything; ebreak beats ecall; st_mis alone
        wb_pc_i = 32'h44; e_inst_addr_mis_i = 1'b1; e_st_addr_mis_i = 1'b1; e_break_i = 1'b1;
        push_trap(32'd0, 32'h44, 32'h44, 32'h200);
        fire();
        wb_pc_i = 32'h48; e_break_i = 1'b1; e_ecall_i = 1'b1;
        push_trap(32'd3, 32'h48, 32'h48, 32'h200);
        fire();
        wb_pc_i = 32'h4C; wb_mem_addr_i = 32'h2002; e_st_addr_mis_i = 1'b1;
        push_trap(32'd6, 32'h2002, 32'h4C, 32'h200);
        fire();

        // Vectored timer interrupt
        mtvec_i = 32'h301; mie_i = 32'h80; mstatus_mie_i = 1'b1;
        wb_pc_i = 32'h80; xint_mtip_i = 1'b1; e_illegal_inst_i = 1'b1;
        push_trap(32'h8000_0007, 32'h0, 32'h80, 32'h31C);
        fire();

        // Same interrupt with global enable off: nothing taken
        mstatus_mie_i = 1'b0; xint_mtip_i = 1'b1;
        fire();
        check("mie_off_stall", 64'(stall_o), 64'd0);

        // Pending but not enabled in mie: nothing taken
        mstatus_mie_i = 1'b1; mie_i = 32'h0; xint_meip_i = 1'b1;
        fire();

        // Vectored external interrupt
        mie_i = 32'h888; xint_meip_i = 1'b1; wb_pc_i = 32'h90;
        push_trap(32'h8000_000B, 32'h0, 32'h90, 32'h32C);
        fire();

        // meip + msip + ecall, direct mode: meip wins
        mtvec_i = 32'h200; wb_pc_i = 32'h88;
        xint_meip_i = 1'b1; xint_msip_i = 1'b1; e_ecall_i = 1'b1;
        push_trap(32'h8000_000B, 32'h0, 32'h88, 32'h200);
        fire();

        // msip over mtip
        xint_msip_i = 1'b1; xint_mtip_i = 1'b1; wb_pc_i = 32'h8C;
        push_trap(32'h8000_0003, 32'h0, 32'h8C, 32'h200);
        fire();

        // MRET to 0x84, then ecall in the first IDLE cycle after REDIRECT
        mstatus_mie_i = 1'b0; mepc_i = 32'h84; is_mret_i = 1'b1;
        push_mret(32'h84);
        fire();
        wb_pc_i = 32'hA0; e_ecall_i = 1'b1;
        push_trap(32'd11, 32'h0, 32'hA0, 32'h200);
        fire();

        // MRET target low bits forced to zero
        mepc_i = 32'h87; is_mret_i = 1'b1;
        push_mret(32'h84);
        fire();

        // Exception without wb_valid: ignored
        e_illegal_inst_i = 1'b1;
        @(posedge clk_i); #1;
        check("no_valid_stall", 64'(stall_o), 64'd0);
        clear_events();

        // Reset asserted during COMMIT aborts the sequence
        wb_pc_i = 32'hC0; wb_inst_i = 32'hDEAD_BEEF; e_illegal_inst_i = 1'b1;
        push_trap(32'd2, 32'hDEAD_BEEF, 32'hC0, 32'h200);
        wb_valid_i = 1'b1;
        @(posedge clk_i); #1;
        clear_events();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        sb_q.delete();
        #1;
        check("rst_mid_stall",   64'(stall_o), 64'd0);
        check("rst_mid_we",      64'(trap_we_o), 64'd0);
        check("rst_mid_redir",   64'(redirect_o), 64'd0);
        check("rst_mid_mcause",  64'(mcause_o), 64'd0);
        check("rst_mid_mtval",   64'(mtval_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;

        check("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
